// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding,
// default operand width and the iteration-counter width helper.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Two bits cover the four phases of one division.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The counter has to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step on magnitudes. The partial remainder is shifted
// left to take in the next dividend bit (WIDTH+1 bits wide). The divisor is
// then trial-subtracted. The difference is kept when it is non-negative;
// otherwise the shifted value is restored.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,  // partial remainder, always < i_div
  input  logic [WIDTH-1:0] i_div,  // divisor magnitude, non-zero
  input  logic             i_bit,  // next dividend bit, MSB first
  output logic [WIDTH-1:0] o_rem,  // next partial remainder, < i_div
  output logic             o_q_bit // quotient bit produced by this step
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};

  // A non-negative trial difference is the same as shifted >= divisor.
  assign o_q_bit = (w_shift >= {1'b0, i_div});

  // The difference is only kept when it is below the divisor. It then fits in
  // WIDTH bits, so modular subtraction of the low bits gives the exact value.
  assign w_diff = w_shift[WIDTH-1:0] - i_div;

  assign o_rem = o_q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider. It takes the magnitudes of both operands and
// produces one restoring-division quotient bit per clock. A final step
// applies the signs: the quotient truncates toward zero and the remainder
// takes the sign of the dividend. Start/busy/done handshake.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;      // original dividend, returned on divide-by-zero
  logic [WIDTH-1:0] r_dvd;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_dvs;    // divisor magnitude
  logic [WIDTH-1:0] r_rem;    // partial remainder magnitude
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rmdr;
  logic             r_dbz;
  logic             r_sign_q;
  logic             r_sign_r;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_q_bit;
  logic             w_b_zero;

  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits when the
  // value is read as unsigned.
  assign w_a_mag  = a[WIDTH-1] ? -a : a;
  assign w_b_mag  = b[WIDTH-1] ? -b : b;
  assign w_b_zero = (b == '0);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem   (r_rem),
    .i_div   (r_dvs),
    .i_bit   (r_dvd[WIDTH-1]),
    .o_rem   (w_rem_nxt),
    .o_q_bit (w_q_bit)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every signal is given a default first, so no path can leave it
    // unassigned and infer a latch.
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = w_b_zero ? FIX : CALC;
      CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and sign fix-up of the results.
  always_ff @(posedge clk) begin
    // NOTE: the datapath has no memories, so every register is reset. This
    // keeps the visible results and internal state defined after reset.
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_rmdr   <= '0;
      r_dbz    <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            r_sign_r <= a[WIDTH-1];
            r_dvd    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_rem    <= '0;
            r_cnt    <= w_b_zero ? '0 : CNT_W'(WIDTH);
            r_dbz    <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          if (r_dvs == '0) begin
            r_quot <= '1;
            r_rmdr <= r_a;
            r_dbz  <= 1'b1;
          end else begin
            // -2^(WIDTH-1) / -1 wraps back to -2^(WIDTH-1) here by design.
            r_quot <= r_sign_q ? -r_dvd : r_dvd;
            r_rmdr <= r_sign_r ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rmdr;
  assign div_by_zero = r_dbz;

endmodule
